// File: rtl/iodelay_array_if.sv
// rtl/iodelay_array_if.sv - per-channel data, tap-control and calibration signals of iodelay_array
interface iodelay_array_if #(
  parameter int CHANNELS = 4,
  parameter int MAX_TAPS = 16
);
  localparam int TAP_W = $clog2(MAX_TAPS);

  logic                      CAL;
  logic [CHANNELS-1:0]       CE;
  logic [CHANNELS-1:0]       INC;
  logic [CHANNELS-1:0]       IDATAIN;
  logic [CHANNELS-1:0]       ODATAIN;
  logic [CHANNELS-1:0]       T;
  logic [CHANNELS-1:0]       DATAOUT;
  logic [CHANNELS-1:0]       DOUT;
  logic [CHANNELS-1:0]       TOUT;
  logic                      BUSY;
  logic [CHANNELS*TAP_W-1:0] TAP_VALUE;

  // Driver side: the I/O wrapper or a testbench
  modport master (
    output CAL, CE, INC, IDATAIN, ODATAIN, T,
    input  DATAOUT, DOUT, TOUT, BUSY, TAP_VALUE
  );

  // Delay-array side
  modport slave (
    input  CAL, CE, INC, IDATAIN, ODATAIN, T,
    output DATAOUT, DOUT, TOUT, BUSY, TAP_VALUE
  );
endinterface

// File: rtl/iodelay_array.sv
// rtl/iodelay_array.sv - cycle-accurate multi-channel programmable delay line with tap counters and calibration
module iodelay_array #(
  parameter int    CHANNELS           = 4,
  parameter int    MAX_TAPS           = 16,
  parameter string IDELAY_TYPE        = "VARIABLE_FROM_ZERO",
  parameter int    IDELAY_VALUE       = 0,
  parameter string COUNTER_WRAPAROUND = "WRAPAROUND",
  parameter int    CAL_CYCLES         = 8
) (
  input logic            CLK,
  input logic            RST_N,
  iodelay_array_if.slave io_if
);
  localparam int TAP_W = $clog2(MAX_TAPS);
  localparam bit IS_FIXED = (IDELAY_TYPE == "FIXED");
  localparam bit IS_WRAP  = (COUNTER_WRAPAROUND == "WRAPAROUND");
  localparam int START_INT = (IDELAY_TYPE == "VARIABLE_FROM_HALF_MAX") ? (MAX_TAPS / 2) : IDELAY_VALUE;
  localparam logic [TAP_W-1:0] TAP_START = TAP_W'(START_INT);
  localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(MAX_TAPS - 1);
  localparam logic [7:0]       CNT_LOAD  = 8'(CAL_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_CAL_BUSY} state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [TAP_W-1:0]   tap_q [CHANNELS];
  logic [TAP_W-1:0]   tap_d [CHANNELS];
  // Stage s holds IDATAIN as sampled s+1 edges ago; tap k reads stage k-1
  logic [MAX_TAPS-2:0] line_q [CHANNELS];

  logic                      busy;
  logic                      tap_load;
  logic                      adj_en;
  logic [CHANNELS-1:0]       dataout;
  logic [CHANNELS*TAP_W-1:0] tap_value;

  // Calibration state and countdown register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next calibration state: accept CAL only from IDLE, count down, return when the count expires
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (io_if.CAL) begin
          state_d = ST_CAL_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_CAL_BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control decoded from the calibration state; a CAL in IDLE pre-empts that cycle's tap adjust
  always_comb begin
    busy     = (state_q == ST_CAL_BUSY);
    tap_load = (state_q == ST_CAL_BUSY) && (cnt_q == 8'd0);
    adj_en   = (state_q == ST_IDLE) && !io_if.CAL && !IS_FIXED;
  end

  // Per-channel tap next value: reload at end of calibration, else step with wrap or saturation
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      tap_d[c] = tap_q[c];
      if (tap_load) begin
        tap_d[c] = TAP_START;
      end else if (adj_en && io_if.CE[c]) begin
        if (io_if.INC[c]) begin
          if (tap_q[c] == TAP_LAST) tap_d[c] = IS_WRAP ? '0 : TAP_LAST;
          else                      tap_d[c] = tap_q[c] + TAP_W'(1);
        end else begin
          if (tap_q[c] == '0) tap_d[c] = IS_WRAP ? TAP_LAST : '0;
          else                tap_d[c] = tap_q[c] - TAP_W'(1);
        end
      end
    end
  end

  // Tap counters
  always_ff @(posedge CLK) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!RST_N) tap_q[c] <= TAP_START;
      else        tap_q[c] <= tap_d[c];
    end
  end

  // Delay lines shift every cycle, independent of calibration
  always_ff @(posedge CLK) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!RST_N) begin
        line_q[c] <= '0;
      end else begin
        line_q[c][0] <= io_if.IDATAIN[c];
        for (int s = 1; s < MAX_TAPS - 1; s++) begin
          line_q[c][s] <= line_q[c][s-1];
        end
      end
    end
  end

  // Tap selects the delay-line stage; tap 0 is a straight combinational path
  always_comb begin
    dataout = io_if.IDATAIN;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 1; k < MAX_TAPS; k++) begin
        if (tap_q[c] == TAP_W'(k)) dataout[c] = line_q[c][k-1];
      end
    end
  end

  // Pack taps onto the flat status bus, channel i at [i*TAP_W +: TAP_W]
  always_comb begin
    tap_value = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tap_value[c*TAP_W +: TAP_W] = tap_q[c];
    end
  end

  assign io_if.DATAOUT   = dataout;
  assign io_if.DOUT      = io_if.ODATAIN;
  assign io_if.TOUT      = io_if.T;
  assign io_if.BUSY      = busy;
  assign io_if.TAP_VALUE = tap_value;

endmodule

// File: tb/tb_iodelay_array.sv
// tb/tb_iodelay_array.sv - self-checking bench for iodelay_array over four parameter sets
module tb_iodelay_array;
  localparam int CH = 4;
  localparam int MT = 16;
  localparam int TW = 4;
  localparam int ND = 4;

  // Instance 0: half-max/wrap, 1: zero/wrap, 2: zero/stay (CAL_CYCLES=3), 3: fixed at 5
  int start_tap [ND] = '{8, 0, 0, 5};
  bit wrap_mode [ND] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit fixed_mode[ND] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic          cal  [ND];
  logic [CH-1:0] ce   [ND];
  logic [CH-1:0] inc  [ND];
  logic [CH-1:0] idat [ND];
  logic [CH-1:0] odat [ND];
  logic [CH-1:0] tt   [ND];
  wire  [CH-1:0]    dataout [ND];
  wire  [CH-1:0]    dout    [ND];
  wire  [CH-1:0]    tout    [ND];
  wire              busy    [ND];
  wire  [CH*TW-1:0] tapv    [ND];

  int model_tap [ND][CH];
  int n_tests = 0;
  int n_fail  = 0;

  iodelay_array_if #(.CHANNELS(CH), .MAX_TAPS(MT)) bus_if [ND] ();

  for (genvar g = 0; g < ND; g++) begin : g_conn
    assign bus_if[g].CAL     = cal[g];
    assign bus_if[g].CE      = ce[g];
    assign bus_if[g].INC     = inc[g];
    assign bus_if[g].IDATAIN = idat[g];
    assign bus_if[g].ODATAIN = odat[g];
    assign bus_if[g].T       = tt[g];
    assign dataout[g] = bus_if[g].DATAOUT;
    assign dout[g]    = bus_if[g].DOUT;
    assign tout[g]    = bus_if[g].TOUT;
    assign busy[g]    = bus_if[g].BUSY;
    assign tapv[g]    = bus_if[g].TAP_VALUE;
  end

  iodelay_array #(.CHANNELS(CH), .MAX_TAPS(MT), .IDELAY_TYPE("VARIABLE_FROM_HALF_MAX"),
                  .IDELAY_VALUE(0), .COUNTER_WRAPAROUND("WRAPAROUND"), .CAL_CYCLES(8))
    u_half (.CLK(CLK), .RST_N(RST_N), .io_if(bus_if[0]));
  iodelay_array #(.CHANNELS(CH), .MAX_TAPS(MT), .IDELAY_TYPE("VARIABLE_FROM_ZERO"),
                  .IDELAY_VALUE(0), .COUNTER_WRAPAROUND("WRAPAROUND"), .CAL_CYCLES(8))
    u_zero (.CLK(CLK), .RST_N(RST_N), .io_if(bus_if[1]));
  iodelay_array #(.CHANNELS(CH), .MAX_TAPS(MT), .IDELAY_TYPE("VARIABLE_FROM_ZERO"),
                  .IDELAY_VALUE(0), .COUNTER_WRAPAROUND("STAY_AT_LIMIT"), .CAL_CYCLES(3))
    u_stay (.CLK(CLK), .RST_N(RST_N), .io_if(bus_if[2]));
  iodelay_array #(.CHANNELS(CH), .MAX_TAPS(MT), .IDELAY_TYPE("FIXED"),
                  .IDELAY_VALUE(5), .COUNTER_WRAPAROUND("WRAPAROUND"), .CAL_CYCLES(8))
    u_fixed (.CLK(CLK), .RST_N(RST_N), .io_if(bus_if[3]));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int model_next(int d, int t, bit up);
    if (fixed_mode[d]) return t;
    if (up) return (t == MT - 1) ? (wrap_mode[d] ? 0 : MT - 1) : t + 1;
    return (t == 0) ? (wrap_mode[d] ? MT - 1 : 0) : t - 1;
  endfunction

  task automatic reset_model();
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < CH; c++) model_tap[d][c] = start_tap[d];
  endtask

  // Pulse CE on the masked channels for n consecutive cycles
  task automatic adjust(int d, logic [CH-1:0] mask, bit up, int n);
    for (int i = 0; i < n; i++) begin
      ce[d]  = mask;
      inc[d] = {CH{up}};
      for (int c = 0; c < CH; c++)
        if (mask[c]) model_tap[d][c] = model_next(d, model_tap[d][c], up);
      tick();
    end
    ce[d]  = '0;
    inc[d] = '0;
  endtask

  // Scoreboard: each driven IDATAIN word is pushed; DATAOUT on channel c is due after model_tap cycles
  task automatic run_delay(int d, int n, string name);
    logic [CH-1:0] hist[$];
    logic [CH-1:0] v;
    int t;
    for (int i = 0; i < n; i++) begin
      if (i == 0)       v = {CH{1'b1}};
      else if (i <= MT) v = '0;
      else              v = CH'($urandom);
      idat[d] = v;
      hist.push_front(v);
      if (hist.size() > MT) void'(hist.pop_back());
      #1;
      for (int c = 0; c < CH; c++) begin
        t = model_tap[d][c];
        if (hist.size() > t) begin
          n_tests++;
          if (dataout[d][c] !== hist[t][c]) begin
            n_fail++;
            $display("FAIL %s dut%0d ch%0d cyc%0d dataout: got %b expected %b", name, d, c, i, dataout[d][c], hist[t][c]);
          end
        end
      end
      tick();
    end
    idat[d] = '0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    for (int d = 0; d < ND; d++) begin
      cal[d] = 1'b0; ce[d] = '0; inc[d] = '0; idat[d] = '0; odat[d] = '0; tt[d] = '0;
    end
    repeat (3) tick();
    RST_N = 1'b1;
    reset_model();
    #1;
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if (busy[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy dut%0d: got %b expected 0", d, busy[d]);
      end
      for (int c = 0; c < CH; c++) begin
        n_tests++;
        if (tapv[d][c*TW +: TW] !== TW'(start_tap[d])) begin
          n_fail++;
          $display("FAIL reset_tap dut%0d ch%0d: got %0d expected %0d", d, c, tapv[d][c*TW +: TW], start_tap[d]);
        end
      end
    end
    n_tests++;
    if (dataout[0] !== '0) begin
      n_fail++;
      $display("FAIL reset_dataout dut0: got %b expected 0000", dataout[0]);
    end
  endtask

  task automatic test_half_delay();
    run_delay(0, 40, "half_delay");
  endtask

  task automatic test_zero_adjust();
    run_delay(1, 12, "zero_passthru");
    adjust(1, 4'b0010, 1'b1, 3);
    #1;
    for (int c = 0; c < CH; c++) begin
      n_tests++;
      if (tapv[1][c*TW +: TW] !== ((c == 1) ? 4'd3 : 4'd0)) begin
        n_fail++;
        $display("FAIL zero_adjust_tap ch%0d: got %0d expected %0d", c, tapv[1][c*TW +: TW], (c == 1) ? 3 : 0);
      end
    end
    run_delay(1, 24, "zero_adjust_delay");
  endtask

  task automatic test_wrap();
    int exp_seq [4] = '{15, 0, 15, 0};
    int stay_seq[4] = '{15, 15, 0, 0};
    for (int s = 0; s < 4; s++) begin
      adjust(1, 4'b0001, (s != 2), (s == 0) ? 15 : 1);
      #1;
      n_tests++;
      if (tapv[1][0 +: TW] !== TW'(exp_seq[s])) begin
        n_fail++;
        $display("FAIL wrap_step%0d: got %0d expected %0d", s, tapv[1][0 +: TW], exp_seq[s]);
      end
    end
    for (int s = 0; s < 4; s++) begin
      adjust(2, 4'b0001, (s < 2), (s == 0 || s == 2) ? 15 : 1);
      #1;
      n_tests++;
      if (tapv[2][0 +: TW] !== TW'(stay_seq[s])) begin
        n_fail++;
        $display("FAIL stay_step%0d: got %0d expected %0d", s, tapv[2][0 +: TW], stay_seq[s]);
      end
    end
  endtask

  task automatic test_cal();
    bit busy_exp[$];
    bit e;
    adjust(1, 4'b0100, 1'b1, 5);
    cal[1] = 1'b1;
    for (int i = 0; i < 8; i++) busy_exp.push_back(1'b1);
    busy_exp.push_back(1'b0);
    tick();
    cal[1] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ce[1]  = (i < 8) ? CH'($urandom) : '0;
      inc[1] = CH'($urandom);
      if (i == 8)
        for (int c = 0; c < CH; c++) model_tap[1][c] = start_tap[1];
      #1;
      e = busy_exp.pop_front();
      n_tests++;
      if (busy[1] !== e) begin
        n_fail++;
        $display("FAIL cal_busy cyc%0d: got %b expected %b", i, busy[1], e);
      end
      for (int c = 0; c < CH; c++) begin
        n_tests++;
        if (tapv[1][c*TW +: TW] !== TW'(model_tap[1][c])) begin
          n_fail++;
          $display("FAIL cal_tap cyc%0d ch%0d: got %0d expected %0d", i, c, tapv[1][c*TW +: TW], model_tap[1][c]);
        end
      end
      tick();
    end
    ce[1] = '0;
    inc[1] = '0;
    // CAL held high on the 3-cycle instance: re-accepted on the single idle cycle between bursts
    cal[2] = 1'b1;
    for (int i = 0; i < 12; i++) busy_exp.push_back((i % 4) != 3);
    tick();
    for (int i = 0; i < 12; i++) begin
      #1;
      e = busy_exp.pop_front();
      n_tests++;
      if (busy[2] !== e) begin
        n_fail++;
        $display("FAIL cal_held cyc%0d: got %b expected %b", i, busy[2], e);
      end
      if (i == 11) cal[2] = 1'b0;
      tick();
    end
  endtask

  task automatic test_cal_ce_reset();
    adjust(1, 4'b0001, 1'b1, 2);
    cal[1] = 1'b1;
    ce[1]  = 4'b0001;
    inc[1] = 4'b0001;
    tick();
    cal[1] = 1'b0;
    ce[1]  = '0;
    inc[1] = '0;
    #1;
    n_tests++;
    if (busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL calce_busy: got %b expected 1", busy[1]);
    end
    n_tests++;
    if (tapv[1][0 +: TW] !== 4'd2) begin
      n_fail++;
      $display("FAIL calce_tap: got %0d expected 2", tapv[1][0 +: TW]);
    end
    tick();
    tick();
    RST_N = 1'b0;
    tick();
    reset_model();
    #1;
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if (busy[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL midcal_reset_busy dut%0d: got %b expected 0", d, busy[d]);
      end
      for (int c = 0; c < CH; c++) begin
        n_tests++;
        if (tapv[d][c*TW +: TW] !== TW'(start_tap[d])) begin
          n_fail++;
          $display("FAIL midcal_reset_tap dut%0d ch%0d: got %0d expected %0d", d, c, tapv[d][c*TW +: TW], start_tap[d]);
        end
      end
    end
    RST_N = 1'b1;
    adjust(1, 4'b0010, 1'b1, 1);
    for (int i = 0; i < 12; i++) begin
      #1;
      n_tests++;
      if (busy[1] !== 1'b0 || tapv[1][1*TW +: TW] !== 4'd1) begin
        n_fail++;
        $display("FAIL no_reload cyc%0d: got busy=%b tap=%0d expected busy=0 tap=1", i, busy[1], tapv[1][1*TW +: TW]);
      end
      tick();
    end
  endtask

  task automatic test_fixed();
    adjust(3, 4'b1111, 1'b1, 4);
    adjust(3, 4'b1111, 1'b0, 7);
    #1;
    for (int c = 0; c < CH; c++) begin
      n_tests++;
      if (tapv[3][c*TW +: TW] !== 4'd5) begin
        n_fail++;
        $display("FAIL fixed_tap ch%0d: got %0d expected 5", c, tapv[3][c*TW +: TW]);
      end
    end
    run_delay(3, 24, "fixed_delay");
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < ND; d++) begin
        odat[d] = CH'($urandom);
        tt[d]   = CH'($urandom);
      end
      #1;
      for (int d = 0; d < ND; d++) begin
        n_tests++;
        if (dout[d] !== odat[d] || tout[d] !== tt[d]) begin
          n_fail++;
          $display("FAIL passthru dut%0d: got dout=%b tout=%b expected dout=%b tout=%b", d, dout[d], tout[d], odat[d], tt[d]);
        end
      end
      #2;
    end
  endtask

  initial begin
    test_reset();
    test_half_delay();
    test_zero_adjust();
    test_wrap();
    test_cal();
    test_cal_ce_reset();
    test_fixed();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
